immgen_pipe: RTL and testbench
==============================

Name: immgen_pipe

Overview:
Registered, handshaked immediate generator for the decode stage of the pipelined core. It covers all RV32I immediate formats (I, S, B, U, J, shift-amount) and is parametrised in XLEN. It also computes the PC-relative target (pc+imm or pc+4) and flags unsupported opcodes. It sits between fetch/decode and the issue stage, with a valid/ready interface on each side and a 2-entry skid buffer, so back-pressure never drops or duplicates an instruction.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; immediate, pc and target widths.
SHW, $clog2(XLEN), shift-amount field width (5 for XLEN=32, 6 for XLEN=64); derived, not overridden.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  upstream instruction valid.
in_ready  out  1  block can accept an instruction this cycle.
in_instr  in  32  raw instruction word.
in_pc  in  XLEN  PC of in_instr.
out_valid  out  1  output bundle valid.
out_ready  in  1  downstream accepts the bundle this cycle.
out_imm  out  XLEN  sign- or zero-extended immediate.
out_fmt  out  3  format code from the package enum.
out_target  out  XLEN  pc+imm for B/J/AUIPC, otherwise pc+4.
out_illegal  out  1  opcode not supported.

Behaviour:
- Reset (rst=1 at an edge): out_valid=0, skid_valid=0, out_imm=0, out_target=0, out_fmt=FMT_NONE, out_illegal=0. in_ready=0 while rst=1. Reset mid-stream discards both held entries; nothing issues afterwards.
- in_ready = !rst && !skid_valid. It is driven from a register, with no combinational path from out_ready.
- Accept on in_valid && in_ready. Emit on out_valid && out_ready.
- Latency: an accepted instruction appears on the outputs the next cycle when the output stage is empty or draining.
- The output stage loads when it is empty or firing. Load source:
  - the skid entry if skid_valid;
  - otherwise the new input if one is accepted.
- If the output is stalled (out_valid && !out_ready) and an input is accepted, the input goes to the skid entry and in_ready drops on the next cycle.
- Order is strictly FIFO. An accept and an emit in the same cycle are both honoured.
- Outputs hold stable while out_valid && !out_ready.
- Decode on instr[6:0]:
  - 0000011, 1100111, 1110011 → I: sext(instr[31:20]).
  - 0010011 with funct3 001 or 101 → I: zext(instr[20+SHW-1:20]).
  - 0010011 with any other funct3 → I: sext(instr[31:20]).
  - 0100011 → S: sext({instr[31:25], instr[11:7]}).
  - 1100011 → B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 0110111, 0010111 → U: sext({instr[31:12], 12'b0}) to XLEN.
  - 1101111 → J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 0110011 → R: imm=0.
  - Anything else → FMT_NONE, imm=0, out_illegal=1.
- Target: pc+imm for B, J and opcode 0010111; pc+4 for all other formats. Arithmetic is modulo 2^XLEN, and wrap-around is silent.
- The decode logic is purely combinational between the input mux and the output register, computed from whichever source loads.

Decomposition:
- Package immgen_pkg holds:
  - fmt_e enum (3 bits): FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_NONE=7.
  - opcode localparams: OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG.
- Sub-module immgen_decode (combinational, parametrised by XLEN) maps {instr, pc} → {imm, fmt, target, illegal}. immgen_pipe wraps it with the output register and skid buffer.

Test Plan:
- XLEN=32, addi x1,x0,-1 (0xFFF00093), pc=0x0, out_ready=1 → next cycle out_valid=1, imm=0xFFFFFFFF, fmt=I, target=0x4.
- sw x1,-4(x2) (0xFE112E23) → imm=0xFFFFFFFC, fmt=S. Then slli (0x00311093) → imm=0x00000003.
- beq x0,x0,-8 (0xFE000CE3), pc=0x100 → imm=0xFFFFFFF8, fmt=B, target=0x0F8.
- jal x1,+8 (0x008000EF), pc=0x200 → imm=8, fmt=J, target=0x208.
  - lui x0,0x12345 (0x12345037) → imm=0x12345000, fmt=U.
  - XLEN=64: lui with instr[31]=1 (0x80000037) → imm=0xFFFFFFFF80000000.
- Back-pressure: hold out_ready=0, present A, B, C back-to-back → A on output, B in skid, in_ready=0, C held upstream. Then raise out_ready → A, B, C emitted in order, one per cycle, none dropped or duplicated.
- Illegal opcode 0x0000007F → fmt=NONE, imm=0, illegal=1. Assert rst with A on output and B in skid → after reset out_valid=0, in_ready=1, and no stale emit.

Source files
------------

// File: rtl/immgen_pkg.sv
// Shared types and opcode constants for the immediate generator.
package immgen_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/immgen_decode.sv
// Combinational immediate/format/target decode for one instruction word.
module immgen_decode
    import immgen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic [XLEN-1:0] target,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    logic       pc_rel;
    logic [2:0] funct3;

    assign funct3 = instr[14:12];

    // Opcode decode; size casts of signed fields perform the sign extension.
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        pc_rel  = 1'b0;
        case (instr[6:0])
            OP_LOAD, OP_JALR, OP_SYSTEM: begin
                fmt = FMT_I;
                imm = XLEN'($signed(instr[31:20]));
            end
            OP_IMM: begin
                fmt = FMT_I;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // Shift amount is zero-extended; upper bits hold funct7.
                    imm = XLEN'(instr[20 +: SHW]);
                end else begin
                    imm = XLEN'($signed(instr[31:20]));
                end
            end
            OP_STORE: begin
                fmt = FMT_S;
                imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            OP_BRANCH: begin
                fmt    = FMT_B;
                pc_rel = 1'b1;
                imm    = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                        instr[11:8], 1'b0}));
            end
            OP_LUI: begin
                fmt = FMT_U;
                imm = XLEN'($signed({instr[31:12], 12'b0}));
            end
            OP_AUIPC: begin
                fmt    = FMT_U;
                pc_rel = 1'b1;
                imm    = XLEN'($signed({instr[31:12], 12'b0}));
            end
            OP_JAL: begin
                fmt    = FMT_J;
                pc_rel = 1'b1;
                imm    = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                        instr[30:21], 1'b0}));
            end
            OP_REG: begin
                fmt = FMT_R;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // Wrap-around on the add is intentional and silent.
    assign target = pc + (pc_rel ? imm : XLEN'(4));

endmodule

// File: rtl/immgen_pipe.sv
// Registered immediate generator with a one-entry skid behind the output register.
//
// Handshake: a transfer happens on a side only in a cycle where valid and ready
// are both high at the rising edge. Once out_valid is raised, the bundle holds
// unchanged until out_ready is seen. in_ready depends only on rst and the skid
// register, never on out_ready.
module immgen_pipe
    import immgen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output fmt_e            out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    logic            skid_valid;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;

    logic            accept;
    logic            load;
    logic [31:0]     src_instr;
    logic [XLEN-1:0] src_pc;
    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic [XLEN-1:0] dec_target;
    logic            dec_illegal;

    assign in_ready  = !rst && !skid_valid;
    assign accept    = in_valid && in_ready;
    // Output register may take a new bundle when empty or emitting this cycle.
    assign load      = !out_valid || out_ready;
    // The skid entry is older than any new input, so it always wins.
    assign src_instr = skid_valid ? skid_instr : in_instr;
    assign src_pc    = skid_valid ? skid_pc    : in_pc;

    immgen_decode #(.XLEN(XLEN)) u_decode (
        .instr   (src_instr),
        .pc      (src_pc),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .target  (dec_target),
        .illegal (dec_illegal)
    );

    // Output stage: load decoded bundle from skid or input, else go empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_imm     <= '0;
            out_fmt     <= FMT_NONE;
            out_target  <= '0;
            out_illegal <= 1'b0;
        end else if (load) begin
            if (skid_valid || accept) begin
                out_valid   <= 1'b1;
                out_imm     <= dec_imm;
                out_fmt     <= dec_fmt;
                out_target  <= dec_target;
                out_illegal <= dec_illegal;
            end else begin
                out_valid   <= 1'b0;
            end
        end
    end

    // Skid entry: catch an accepted input while stalled, release on next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (skid_valid && load) begin
            skid_valid <= 1'b0;
        end else if (accept && !load) begin
            skid_valid <= 1'b1;
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
        end
    end

endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: directed cases, back-pressure, reset flush, random traffic.
module tb_immgen_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT (XLEN=32) ----------------
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic [31:0] out_target;
    logic        out_illegal;

    immgen_pipe #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt),
        .out_target(out_target), .out_illegal(out_illegal)
    );

    // ---------------- DUT (XLEN=64) ----------------
    logic        in_valid_64 = 1'b0;
    logic        in_ready_64;
    logic [31:0] in_instr_64 = '0;
    logic [63:0] in_pc_64 = '0;
    logic        out_valid_64;
    logic        out_ready_64 = 1'b1;
    logic [63:0] out_imm_64;
    logic [2:0]  out_fmt_64;
    logic [63:0] out_target_64;
    logic        out_illegal_64;

    immgen_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_64), .in_ready(in_ready_64),
        .in_instr(in_instr_64), .in_pc(in_pc_64),
        .out_valid(out_valid_64), .out_ready(out_ready_64),
        .out_imm(out_imm_64), .out_fmt(out_fmt_64),
        .out_target(out_target_64), .out_illegal(out_illegal_64)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int n_emit   = 0;
    logic [67:0] exp_q[$];

    task automatic check(input string tag, input logic [131:0] got, input logic [131:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint sx(input longint v, input int bits);
        if (v[bits-1]) return v - (longint'(1) << bits);
        return v;
    endfunction

    // Returns {illegal, fmt[2:0], target[63:0], imm[63:0]} for the given width.
    function automatic logic [131:0] model(input logic [31:0] ins, input logic [63:0] pc,
                                           input int xlen);
        longint imm = 0;
        longint tgt;
        int     fmt = 7;
        bit     ill = 1'b0;
        bit     rel = 1'b0;
        logic [63:0] mask;
        logic [2:0]  f3;
        f3   = ins[14:12];
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        case (ins[6:0])
            7'h03, 7'h67, 7'h73: begin fmt = 1; imm = sx(longint'(ins[31:20]), 12); end
            7'h13: begin
                fmt = 1;
                if (f3 == 3'd1 || f3 == 3'd5)
                    imm = longint'(ins[25:20]) % xlen;
                else
                    imm = sx(longint'(ins[31:20]), 12);
            end
            7'h23: begin fmt = 2; imm = sx(longint'({ins[31:25], ins[11:7]}), 12); end
            7'h63: begin
                fmt = 3; rel = 1'b1;
                imm = sx(longint'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2, 13);
            end
            7'h37: begin fmt = 4; imm = sx(longint'(ins[31:12]) * 4096, 32); end
            7'h17: begin fmt = 4; rel = 1'b1; imm = sx(longint'(ins[31:12]) * 4096, 32); end
            7'h6f: begin
                fmt = 5; rel = 1'b1;
                imm = sx(longint'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2, 21);
            end
            7'h33: begin fmt = 0; imm = 0; end
            default: begin fmt = 7; ill = 1'b1; imm = 0; end
        endcase
        tgt = rel ? longint'(pc) + imm : longint'(pc) + 4;
        return {ill, 3'(fmt), 64'(tgt) & mask, 64'(imm) & mask};
    endfunction

    function automatic logic [67:0] exp32(input logic [31:0] ins, input logic [31:0] pc);
        logic [131:0] m;
        m = model(ins, {32'h0, pc}, 32);
        return {m[131:128], m[95:64], m[31:0]};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic        prev_stall = 1'b0;
    logic [67:0] prev_bundle = '0;

    always @(negedge clk) begin
        logic [67:0] cur;
        logic [67:0] e;
        cur = {out_illegal, out_fmt, out_target, out_imm};
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("hold_stable", {63'h0, out_valid, cur}, {63'h0, 1'b1, prev_bundle});
            if (out_valid && out_ready) begin
                n_emit++;
                if (exp_q.size() == 0) begin
                    check("emit_with_empty_queue", 132'(out_valid), 132'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("bundle", 132'(cur), 132'(e));
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(exp32(in_instr, in_pc));
            prev_stall  = out_valid && !out_ready;
            prev_bundle = cur;
        end
    end

    // ---------------- driver tasks ----------------
    // Call right after a rising edge; returns 1 time unit after the accepting edge.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("accept_timeout", 132'(in_ready), 132'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                            input logic [31:0] e_imm, input logic [2:0] e_fmt,
                            input logic [31:0] e_tgt, input logic e_ill);
        out_ready = 1'b1;
        send(instr, pc);
        @(negedge clk);
        check({tag, "_valid"}, 132'(out_valid), 132'(1));
        check({tag, "_imm"}, 132'(out_imm), 132'(e_imm));
        check({tag, "_fmt"}, 132'(out_fmt), 132'(e_fmt));
        check({tag, "_target"}, 132'(out_target), 132'(e_tgt));
        check({tag, "_illegal"}, 132'(out_illegal), 132'(e_ill));
        @(posedge clk); #1;
    endtask

    task automatic directed64(input string tag, input logic [31:0] instr, input logic [63:0] pc,
                              input logic [63:0] e_imm);
        logic [131:0] m;
        m = model(instr, pc, 64);
        in_valid_64 = 1'b1;
        in_instr_64 = instr;
        in_pc_64    = pc;
        @(negedge clk);
        check({tag, "_ready"}, 132'(in_ready_64), 132'(1));
        @(posedge clk); #1;
        in_valid_64 = 1'b0;
        @(negedge clk);
        check({tag, "_valid"}, 132'(out_valid_64), 132'(1));
        check({tag, "_imm"}, 132'(out_imm_64), 132'(e_imm));
        check({tag, "_bundle"}, {out_illegal_64, out_fmt_64, out_target_64, out_imm_64}, m);
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 500; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        check({tag, "_drained"}, 132'(exp_q.size()), 132'(0));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops[11];
        logic [31:0] r;
        ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h00};
        r = $urandom();
        if ($urandom_range(0, 10) == 10) return {r[31:7], 7'($urandom_range(0, 127))};
        return {r[31:7], ops[$urandom_range(0, 9)]};
    endfunction

    // ---------------- main sequence ----------------
    bit rand_done = 1'b0;

    initial begin
        int base_emit;
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 132'(in_ready), 132'(0));
        check("rst_out_valid", 132'(out_valid), 132'(0));
        check("rst_out", {out_illegal, out_fmt, out_target, out_imm}, {1'b0, 3'd7, 64'h0});
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 132'(in_ready), 132'(1));
        @(posedge clk); #1;

        // directed decode cases (XLEN=32)
        directed("addi", 32'hFFF00093, 32'h0,   32'hFFFFFFFF, 3'd1, 32'h4,   1'b0);
        directed("sw",   32'hFE112E23, 32'h40,  32'hFFFFFFFC, 3'd2, 32'h44,  1'b0);
        directed("slli", 32'h00311093, 32'h80,  32'h00000003, 3'd1, 32'h84,  1'b0);
        directed("beq",  32'hFE000CE3, 32'h100, 32'hFFFFFFF8, 3'd3, 32'h0F8, 1'b0);
        directed("jal",  32'h008000EF, 32'h200, 32'h00000008, 3'd5, 32'h208, 1'b0);
        directed("lui",  32'h12345037, 32'h300, 32'h12345000, 3'd4, 32'h304, 1'b0);
        directed("auipc_wrap", 32'h00001017, 32'hFFFFF800, 32'h00001000, 3'd4, 32'h00000800, 1'b0);
        directed("add",  32'h002081B3, 32'h10,  32'h0,        3'd0, 32'h14,  1'b0);
        directed("ill",  32'h0000007F, 32'h20,  32'h0,        3'd7, 32'h24,  1'b1);

        // XLEN=64 cases
        directed64("lui64", 32'h80000037, 64'h1000, 64'hFFFFFFFF80000000);
        directed64("slli64", 32'h03F11093, 64'h2000, 64'h000000000000003F);
        directed64("jal64", 32'hFF9FF0EF, 64'h0000000100000000, 64'hFFFFFFFFFFFFFFF8);

        // back-pressure: A to output, B to skid, C held upstream
        out_ready = 1'b0;
        base_emit = n_emit;
        send(32'h00100093, 32'h400);
        send(32'h00200113, 32'h404);
        @(negedge clk);
        check("bp_in_ready_low", 132'(in_ready), 132'(0));
        check("bp_out_valid", 132'(out_valid), 132'(1));
        check("bp_out_is_a", 132'(out_imm), 132'(1));
        @(posedge clk); #1;
        in_valid = 1'b1; in_instr = 32'h00300193; in_pc = 32'h408;
        repeat (2) begin
            @(negedge clk);
            check("bp_c_held", 132'(in_ready), 132'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h00300193, 32'h408);
        drain("bp");
        check("bp_emit_count", 132'(n_emit - base_emit), 132'(3));

        // reset mid-stream with A on output and B in skid
        out_ready = 1'b0;
        send(32'h00500293, 32'h500);
        send(32'h00600313, 32'h504);
        @(negedge clk);
        check("mid_skid_full", 132'(in_ready), 132'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_in_ready", 132'(in_ready), 132'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_out_valid", 132'(out_valid), 132'(0));
        check("mid_in_ready", 132'(in_ready), 132'(1));
        check("mid_out_cleared", {out_illegal, out_fmt, out_target, out_imm}, {1'b0, 3'd7, 64'h0});
        @(posedge clk); #1;
        out_ready = 1'b1;
        base_emit = n_emit;
        repeat (5) @(posedge clk);
        #1;
        check("mid_no_stale_emit", 132'(n_emit - base_emit), 132'(0));

        // random traffic with random back-pressure
        fork
            begin
                for (int t = 0; t < 400; t++) begin
                    logic [31:0] pc;
                    pc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15))
                                                     : $urandom();
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    if (in_valid == 1'b0) #1;
                    send(rand_instr(), pc);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain("rand");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "timeout");
    end

endmodule
